sar_adc_controller: RTL and testbench
=====================================

# sar_adc_controller

- Successive-approximation ADC controller for the lab's external analog path.
- Drives the same R2R ladder used by the waveform generators as a trial DAC, and reads an external analog comparator (Vin vs. ladder voltage).
- Performs a binary search MSB→LSB and returns a WIDTH-bit code with a one-cycle done pulse.
- Sits beside the waveform generators and shares the R2R ladder pins through a top-level mux.

## Interface
Parameters:
- WIDTH, 8, result and R2R ladder bit width.
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- SETTLE_NS, 1000, ladder plus comparator settling time per trial bit, in ns.
- Derived localparam SETTLE_CYCLES = ceil(CLOCK_FREQ·SETTLE_NS/1e9), which is 100 at the defaults. SETTLE_CYCLES < 3 raises $error at elaboration.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, active-high; low aborts any conversion and forces idle.
- start, input, 1, level-sampled conversion request.
- comp_in, input, 1, asynchronous comparator output; 1 means Vin ≥ V(R2R_out).
- R2R_out, output, WIDTH, trial code driven to the ladder.
- busy, output, 1, high while converting.
- done, output, 1, one-cycle pulse when result updates.
- result, output, WIDTH, last completed conversion code.
- valid, output, 1, high once any conversion has completed since reset.

## Operation
- comp_in passes through a 2-flop synchronizer; all decisions use the synchronized value comp_s.
- States are IDLE, SETTLE and DECIDE. Registers: trial[WIDTH-1:0], bit_idx, cnt, result, valid, done.
- **IDLE:** R2R_out = 0, busy = 0. On an edge where enable=1 and start=1:
  - trial ← 1<<(WIDTH-1), bit_idx ← WIDTH-1, cnt ← SETTLE_CYCLES-1, go to SETTLE.
- **SETTLE:** if cnt==0 go to DECIDE, else cnt ← cnt-1.
- **DECIDE:** if comp_s==0, clear trial[bit_idx].
  - If bit_idx==0: result ← final trial, valid ← 1, done ← 1, go to IDLE.
  - Otherwise: set trial[bit_idx-1], bit_idx ← bit_idx-1, cnt ← SETTLE_CYCLES-1, go to SETTLE.
- R2R_out = trial in SETTLE/DECIDE and 0 in IDLE; it is driven directly from the register (no combinational path from comp_in).
- busy = (state != IDLE).
- done defaults to 0 every cycle unless set by DECIDE.
- start while busy is ignored (no queueing).
- start held high gives back-to-back conversions.
- enable low in any state: next edge goes to IDLE and trial ← 0. result and valid are held, and no done pulse is issued.
- reset_n low, asynchronous, in any state: state=IDLE; trial, result, cnt, bit_idx, done, valid and the synchronizer flops all clear. All outputs read 0 immediately.
- Result arithmetic is unsigned. Output range is 0 to 2^WIDTH-1 with no wrap; an all-ones Vin yields all-ones.

## Timing
- Each bit takes SETTLE_CYCLES+1 clocks: SETTLE_CYCLES in SETTLE plus 1 in DECIDE.
- Call the start-sampling edge E0.
  - The final DECIDE occurs at edge E0 + WIDTH·(SETTLE_CYCLES+1).
  - done and the new result are visible in the cycle after that edge; done is high for exactly 1 cycle.
- Conversion latency at the defaults: 8·101 = 808 clocks, ≈8.08 µs.
- Back-to-back period: WIDTH·(SETTLE_CYCLES+1)+1 clocks, because one IDLE cycle is needed to resample start.
- Comparator sampling delay: comp_s lags comp_in by 2 clocks. SETTLE_CYCLES ≥ 3 ensures comp_s reflects the current trial code.
- The enable abort takes effect at the first edge where enable=0.

## Structure
- Package sar_adc_pkg holds:
  - the typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} sar_state_t;
  - a function for computing SETTLE_CYCLES.
- One sub-module, sync_2ff: a parameterless 1-bit, two-flop synchronizer with clk/reset_n, instantiated for comp_in.
- The counter, FSM and result registers are inline in sar_adc_controller. The team downcounter is not reused because its reset is synchronous active-high.

## Test plan
Common setup: WIDTH=8, SETTLE_NS=40 (SETTLE_CYCLES=4). The comparator model is comp_in = (vin_code ≥ R2R_out), applied with 1-cycle delay.

1. vin_code=0xA5, pulse start → busy high from E0+1; R2R_out first shows 0x80; done at E0+40+1; result=0xA5; valid=1.
2. vin_code=0x00, then 0xFF → result=0x00, then 0xFF; trial sequence for 0xFF is 0x80,0xC0,…,0xFF.
3. start held high, vin_code=0x3C → done pulses every 41 cycles; each result=0x3C; start pulses during busy are ignored.
4. enable dropped at E0+17 → busy=0 and R2R_out=0 at the next edge; no done pulse; result and valid keep their prior values.
5. reset_n asserted mid-conversion (asynchronous, between edges) → all outputs 0 immediately.
   - After release, a new start with vin_code=0x01 gives result=0x01.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and elaboration helpers for the successive-approximation ADC controller.
package sar_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } sar_state_t;

  // Settle time in whole clock cycles, rounded up so the ladder is never under-settled.
  function automatic int calc_settle_cycles(input longint clock_freq, input longint settle_ns);
    longint prod;
    prod = clock_freq * settle_ns;
    return int'((prod + 64'sd999_999_999) / 64'sd1_000_000_000);
  endfunction

endpackage

// File: rtl/sar_adc_controller_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sar_adc_controller.sv
// SAR ADC controller: binary-searches the R2R ladder against an external comparator,
// MSB first, and reports the code with a one-cycle done pulse.
module sar_adc_controller
  import sar_adc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int SETTLE_NS  = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             comp_in,
  output logic [WIDTH-1:0] R2R_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             valid
);

  localparam int SETTLE_CYCLES = calc_settle_cycles(longint'(CLOCK_FREQ), longint'(SETTLE_NS));
  localparam int CNT_W         = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 2;
  localparam int BIDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BIDX_W-1:0] BIDX_TOP   = BIDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  TRIAL_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

  // Fewer than 3 cycles cannot cover the two-flop comparator synchronizer latency.
  if (SETTLE_CYCLES < 3) begin : g_settle_check
    $error("sar_adc_controller: SETTLE_CYCLES=%0d is below the minimum of 3", SETTLE_CYCLES);
  end

  sar_state_t        state_q, state_d;
  logic [WIDTH-1:0]  trial_q, trial_d;
  logic [BIDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  decided;
  logic              comp_s;

  sync_2ff u_comp_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (comp_in),
    .q       (comp_s)
  );

  always_comb begin
    state_d   = state_q;
    trial_d   = trial_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    decided   = trial_q;

    if (!decided[bit_idx_q] || comp_s) begin
      decided = trial_q;
    end else begin
      decided[bit_idx_q] = 1'b0;
    end

    if (!enable) begin
      state_d = IDLE;
      trial_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          trial_d = '0;
          if (start) begin
            trial_d   = TRIAL_MSB;
            bit_idx_d = BIDX_TOP;
            cnt_d     = CNT_RELOAD;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = DECIDE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DECIDE: begin
          // Trial is cleared on completion so the ladder parks at zero while idle.
          if (bit_idx_q == '0) begin
            result_d = decided;
            valid_d  = 1'b1;
            done_d   = 1'b1;
            trial_d  = '0;
            state_d  = IDLE;
          end else begin
            trial_d                     = decided;
            trial_d[bit_idx_q - 1'b1]   = 1'b1;
            bit_idx_d                   = bit_idx_q - 1'b1;
            cnt_d                       = CNT_RELOAD;
            state_d                     = SETTLE;
          end
        end
        default: begin
          state_d = IDLE;
          trial_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      trial_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trial_q   <= trial_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign R2R_out = trial_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Randomized self-checking bench for sar_adc_controller against a binary-search reference model.
module tb_sar_adc_controller;

  localparam int WIDTH = 8;
  localparam int SC    = 4;
  localparam int CONV  = WIDTH * (SC + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             start;
  logic             comp_in;
  logic [WIDTH-1:0] vin_code;
  logic [WIDTH-1:0] R2R_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             valid;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] obs_trials[$];
  logic             busy_at_start;
  logic [WIDTH-1:0] last_result;

  sar_adc_controller #(
    .WIDTH      (WIDTH),
    .CLOCK_FREQ (100_000_000),
    .SETTLE_NS  (40)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .start   (start),
    .comp_in (comp_in),
    .R2R_out (R2R_out),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  // External comparator: Vin against the ladder, refreshed once per cycle.
  always @(negedge clk) comp_in = (vin_code >= R2R_out);

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: largest code c with Vin >= c, found by interval halving.
  function automatic logic [WIDTH-1:0] ref_code(input logic [WIDTH-1:0] vin);
    int lo = 0;
    int hi = 2 ** WIDTH;
    int mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (int'(vin) >= mid) lo = mid;
      else hi = mid;
    end
    return WIDTH'(lo);
  endfunction

  // Reference: ladder code presented while testing bit position "step" (0 = MSB).
  function automatic logic [WIDTH-1:0] ref_trial(input logic [WIDTH-1:0] vin, input int step);
    int acc = 0;
    int t;
    for (int s = 0; s < step; s++) begin
      t = acc + 2 ** (WIDTH - 1 - s);
      if (int'(vin) >= t) acc = t;
    end
    return WIDTH'(acc + 2 ** (WIDTH - 1 - step));
  endfunction

  // Starts one conversion from a negedge and returns at the negedge where done is seen.
  task automatic convert(input logic [WIDTH-1:0] vin, input int pulse_at, output int lat, output bit tmo);
    vin_code = vin;
    obs_trials.delete();
    tmo = 1'b1;
    lat = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_at_start = busy;
    for (int k = 0; k < CONV + 20; k++) begin
      if (busy && (obs_trials.size() == 0 || obs_trials[$] != R2R_out)) obs_trials.push_back(R2R_out);
      if (done) begin
        lat = k;
        tmo = 1'b0;
        break;
      end
      start = (k == pulse_at || k == pulse_at + 7) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    start    = 1'b0;
    vin_code = '0;
    comp_in  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (R2R_out !== '0) begin n_err++; $display("[TB] FAIL reset_r2r: got %h want 00", R2R_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (result !== '0) begin n_err++; $display("[TB] FAIL reset_result: got %h want 00", result); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    bit tmo;
    logic [WIDTH-1:0] vin = 8'hA5;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy); end
    convert(vin, -100, lat, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("[TB] FAIL single_timeout: no done within %0d cycles", CONV + 20); end
    n_cmp++; if (busy_at_start !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy_e0: got %b want 1", busy_at_start); end
    n_cmp++; if (lat !== CONV) begin n_err++; $display("[TB] FAIL single_latency: got %0d want %0d", lat, CONV); end
    n_cmp++; if (result !== ref_code(vin)) begin n_err++; $display("[TB] FAIL single_result: got %h want %h", result, ref_code(vin)); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("[TB] FAIL single_valid: got %b want 1", valid); end
    n_cmp++; if (obs_trials.size() !== WIDTH) begin n_err++; $display("[TB] FAIL single_trial_count: got %0d want %0d", obs_trials.size(), WIDTH); end
    for (int s = 0; s < WIDTH && s < obs_trials.size(); s++) begin
      n_cmp++; if (obs_trials[s] !== ref_trial(vin, s)) begin n_err++; $display("[TB] FAIL single_trial%0d: got %h want %h", s, obs_trials[s], ref_trial(vin, s)); end
    end
    last_result = ref_code(vin);
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL single_done_width: got %b want 0", done); end
    n_cmp++; if (R2R_out !== '0) begin n_err++; $display("[TB] FAIL single_idle_r2r: got %h want 00", R2R_out); end
  endtask

  task automatic test_extremes();
    int lat;
    bit tmo;
    logic [WIDTH-1:0] vins[2];
    vins[0] = '0;
    vins[1] = '1;
    for (int v = 0; v < 2; v++) begin
      convert(vins[v], -100, lat, tmo);
      n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("[TB] FAIL extreme_timeout: vin %h", vins[v]); end
      n_cmp++; if (result !== ref_code(vins[v])) begin n_err++; $display("[TB] FAIL extreme_result: got %h want %h", result, ref_code(vins[v])); end
      n_cmp++; if (obs_trials.size() !== WIDTH) begin n_err++; $display("[TB] FAIL extreme_trial_count: got %0d want %0d", obs_trials.size(), WIDTH); end
      for (int s = 0; s < WIDTH && s < obs_trials.size(); s++) begin
        n_cmp++; if (obs_trials[s] !== ref_trial(vins[v], s)) begin n_err++; $display("[TB] FAIL extreme_trial%0d: got %h want %h", s, obs_trials[s], ref_trial(vins[v], s)); end
      end
      last_result = ref_code(vins[v]);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int lat;
    bit tmo;
    logic [WIDTH-1:0] vin;
    for (int i = 0; i < 10; i++) begin
      vin = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
      convert(vin, -100, lat, tmo);
      n_cmp++; if (lat !== CONV) begin n_err++; $display("[TB] FAIL random_latency: vin %h got %0d want %0d", vin, lat, CONV); end
      n_cmp++; if (result !== ref_code(vin)) begin n_err++; $display("[TB] FAIL random_result: vin %h got %h want %h", vin, result, ref_code(vin)); end
      last_result = ref_code(vin);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    bit tmo;
    bit restarted = 1'b0;
    logic [WIDTH-1:0] vin = 8'h5A;
    convert(vin, 10, lat, tmo);
    n_cmp++; if (lat !== CONV) begin n_err++; $display("[TB] FAIL ignore_latency: got %0d want %0d", lat, CONV); end
    n_cmp++; if (result !== ref_code(vin)) begin n_err++; $display("[TB] FAIL ignore_result: got %h want %h", result, ref_code(vin)); end
    last_result = ref_code(vin);
    repeat (5) begin
      @(negedge clk);
      if (busy) restarted = 1'b1;
    end
    n_cmp++; if (restarted !== 1'b0) begin n_err++; $display("[TB] FAIL ignore_no_queue: busy seen %b want 0", restarted); end
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    logic [WIDTH-1:0] vin = 8'h3C;
    logic [WIDTH-1:0] res_seen[$];
    vin_code = vin;
    start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3 * (CONV + 1) + 20; k++) begin
      if (done) begin
        done_at.push_back(k);
        res_seen.push_back(result);
        if (done_at.size() == 3) break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++; if (done_at.size() !== 3) begin n_err++; $display("[TB] FAIL b2b_count: got %0d done pulses want 3", done_at.size()); end
    for (int i = 0; i < done_at.size(); i++) begin
      n_cmp++; if (done_at[i] !== CONV + i * (CONV + 1)) begin n_err++; $display("[TB] FAIL b2b_period%0d: got %0d want %0d", i, done_at[i], CONV + i * (CONV + 1)); end
      n_cmp++; if (res_seen[i] !== ref_code(vin)) begin n_err++; $display("[TB] FAIL b2b_result%0d: got %h want %h", i, res_seen[i], ref_code(vin)); end
    end
    last_result = ref_code(vin);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable_abort();
    bit seen_done = 1'b0;
    vin_code = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL abort_pre_busy: got %b want 1", busy); end
    enable = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (R2R_out !== '0) begin n_err++; $display("[TB] FAIL abort_r2r: got %h want 00", R2R_out); end
    n_cmp++; if (result !== last_result) begin n_err++; $display("[TB] FAIL abort_result: got %h want %h", result, last_result); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("[TB] FAIL abort_valid: got %b want 1", valid); end
    for (int k = 0; k < CONV + 10; k++) begin
      if (done) seen_done = 1'b1;
      if (k == 5) enable = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_done: got %b want 0", seen_done); end
  endtask

  task automatic test_reset_midconv();
    int lat;
    bit tmo;
    vin_code = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({R2R_out, busy, done, result, valid} !== '0) begin n_err++; $display("[TB] FAIL midreset_outputs: got r2r=%h busy=%b done=%b result=%h valid=%b want all 0", R2R_out, busy, done, result, valid); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    convert(8'h01, -100, lat, tmo);
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_timeout: no done after reset"); end
    n_cmp++; if (result !== ref_code(8'h01)) begin n_err++; $display("[TB] FAIL midreset_result: got %h want %h", result, ref_code(8'h01)); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_valid: got %b want 1", valid); end
  endtask

  initial begin
    $display("[TB] sar_adc_controller bench starting");
    test_reset();
    test_single();
    test_extremes();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_enable_abort();
    test_reset_midconv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
